// File: rtl/jk_updown_counter_if.sv
// Bundles the control inputs and status/excitation outputs of the JK up/down
// counter. The master side drives control and observes status; the counter is
// the slave.
interface jk_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic             tc;
    logic             wrapped;
    logic             load_err;

    modport master (
        output en, up, load, load_val,
        input  count, j_vec, k_vec, tc, wrapped, load_err
    );

    modport slave (
        input  en, up, load, load_val,
        output count, j_vec, k_vec, tc, wrapped, load_err
    );
endinterface

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter whose state bits are updated through JK
// excitation. The J/K terms for the next edge are exported so discrete JK
// stages downstream can follow the same sequence.
module jk_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic               clk,
    input  logic               reset,
    jk_updown_counter_if.slave bus
);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("jk_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    // Highest legal count; comparing against it instead of MODULUS keeps every
    // compare at WIDTH bits even when MODULUS == 2**WIDTH.
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic             load_oor;
    logic             tc;
    logic             wrapped_q;
    logic             load_err_q;

    // Next-state selection: load beats enable, enable beats hold.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        next_count = count_q;
        load_oor   = 1'b0;
        if (bus.load) begin
            if (bus.load_val > TOP) begin
                next_count = TOP;
                load_oor   = 1'b1;
            end else begin
                next_count = bus.load_val;
            end
        end else if (bus.en) begin
            if (bus.up) begin
                next_count = (count_q == TOP) ? '0 : count_q + WIDTH'(1);
            end else begin
                next_count = (count_q == '0) ? TOP : count_q - WIDTH'(1);
            end
        end
    end

    // Excitation: J sets bits that must rise, K clears bits that must fall.
    assign j_vec = ~count_q & next_count;
    assign k_vec = count_q & ~next_count;

    // Terminal count only when this edge would actually wrap.
    assign tc = bus.en & ~bus.load & (bus.up ? (count_q == TOP) : (count_q == '0));

    // State bits as JK flops plus the one-cycle wrap and load-error pulses.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // sample their inputs from the same pre-edge values.
        if (reset) begin
            count_q    <= '0;
            wrapped_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= (j_vec & ~count_q) | (~k_vec & count_q);
            wrapped_q  <= tc;
            load_err_q <= load_oor;
        end
    end

    assign bus.count    = count_q;
    assign bus.j_vec    = j_vec;
    assign bus.k_vec    = k_vec;
    assign bus.tc       = tc;
    assign bus.wrapped  = wrapped_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_jk_updown_counter.sv
// Directed bench for jk_updown_counter (WIDTH=4, MODULUS=10). The stimulus
// process queues hand-computed expectations for each cycle; a monitor process
// pops and compares them on every falling edge.
module tb_jk_updown_counter;

    logic clk = 1'b0;
    logic reset = 1'b1;

    jk_updown_counter_if #(.WIDTH(4)) bus ();

    jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] cnt;
        logic       tc;
        logic       wr;
        logic       le;
        logic       chk_jk;
        logic [3:0] j;
        logic [3:0] k;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   stim_done = 1'b0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check({e.name, ".count"},    bus.count,           e.cnt);
                check({e.name, ".tc"},       {3'b000, bus.tc},       {3'b000, e.tc});
                check({e.name, ".wrapped"},  {3'b000, bus.wrapped},  {3'b000, e.wr});
                check({e.name, ".load_err"}, {3'b000, bus.load_err}, {3'b000, e.le});
                if (e.chk_jk) begin
                    check({e.name, ".j_vec"}, bus.j_vec, e.j);
                    check({e.name, ".k_vec"}, bus.k_vec, e.k);
                end
            end
        end
    end

    // Drive one cycle's inputs just after the rising edge and queue what the
    // DUT must show in that cycle; rmid asserts reset before the next edge.
    task automatic cyc(input string name, input logic rst, input logic rmid,
                       input logic en, input logic up, input logic ld, input logic [3:0] lv,
                       input logic [3:0] ec, input logic etc, input logic ewr, input logic ele,
                       input logic cj, input logic [3:0] ej, input logic [3:0] ek);
        exp_t e;
        reset        = rst;
        bus.en       = en;
        bus.up       = up;
        bus.load     = ld;
        bus.load_val = lv;
        e.name = name; e.cnt = ec; e.tc = etc; e.wr = ewr; e.le = ele;
        e.chk_jk = cj; e.j = ej; e.k = ek;
        sb_q.push_back(e);
        if (rmid) begin
            #1 reset = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: stimulus did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        bus.en = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.load_val = '0;
        @(posedge clk);
        #1;
        //   name        rst rm en up ld lv     cnt tc wr le  jk  j        k
        cyc("rst0",      1, 0, 0, 1, 0, 4'd0,  4'd0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        cyc("rst1",      1, 0, 0, 1, 0, 4'd0,  4'd0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        // Count up through the wrap.
        cyc("t1_c0",     0, 0, 1, 1, 0, 4'd0,  4'd0, 0, 0, 0, 1, 4'b0001, 4'b0000);
        for (int i = 1; i <= 8; i++)
            cyc("t1_up",  0, 0, 1, 1, 0, 4'd0,  4'(i), 0, 0, 0, 0, 4'b0000, 4'b0000);
        cyc("t1_c9",     0, 0, 1, 1, 0, 4'd0,  4'd9, 1, 0, 0, 1, 4'b0000, 4'b1001);
        cyc("t1_c10",    0, 0, 1, 1, 0, 4'd0,  4'd0, 0, 1, 0, 0, 4'b0000, 4'b0000);
        cyc("t1_c11",    0, 0, 1, 1, 0, 4'd0,  4'd1, 0, 0, 0, 0, 4'b0000, 4'b0000);
        cyc("t1_c12",    0, 0, 1, 1, 1, 4'd0,  4'd2, 0, 0, 0, 0, 4'b0000, 4'b0000);
        // Count down through the wrap.
        cyc("t2_d0",     0, 0, 1, 0, 0, 4'd0,  4'd0, 1, 0, 0, 1, 4'b1001, 4'b0000);
        cyc("t2_d1",     0, 0, 1, 0, 0, 4'd0,  4'd9, 0, 1, 0, 0, 4'b0000, 4'b0000);
        cyc("t2_d2",     0, 0, 1, 0, 0, 4'd0,  4'd8, 0, 0, 0, 0, 4'b0000, 4'b0000);
        cyc("t2_d3",     0, 0, 0, 0, 0, 4'd0,  4'd7, 0, 0, 0, 1, 4'b0000, 4'b0000);
        // Legal and out-of-range loads; load beats enable at terminal count.
        cyc("t3_ld6",    0, 0, 0, 1, 1, 4'd6,  4'd7, 0, 0, 0, 1, 4'b0000, 4'b0001);
        cyc("t3_ld13",   0, 0, 0, 1, 1, 4'd13, 4'd6, 0, 0, 0, 1, 4'b1001, 4'b0110);
        cyc("t3_ldtc",   0, 0, 1, 1, 1, 4'd3,  4'd9, 0, 0, 1, 1, 4'b0010, 4'b1000);
        cyc("t3_ld5",    0, 0, 0, 1, 1, 4'd5,  4'd3, 0, 0, 0, 0, 4'b0000, 4'b0000);
        // Excitation values, including a mid-count direction change.
        cyc("t4_5to6",   0, 0, 1, 1, 0, 4'd0,  4'd5, 0, 0, 0, 1, 4'b0010, 4'b0001);
        cyc("t4_6to7",   0, 0, 1, 1, 0, 4'd0,  4'd6, 0, 0, 0, 1, 4'b0001, 4'b0000);
        cyc("t4_7to8",   0, 0, 1, 1, 0, 4'd0,  4'd7, 0, 0, 0, 1, 4'b1000, 4'b0111);
        cyc("t4_8to7",   0, 0, 1, 0, 0, 4'd0,  4'd8, 0, 0, 0, 1, 4'b0111, 4'b1000);
        cyc("t4_7to8b",  0, 0, 1, 1, 0, 4'd0,  4'd7, 0, 0, 0, 1, 4'b1000, 4'b0111);
        cyc("t4_8to9",   0, 0, 1, 1, 0, 4'd0,  4'd8, 0, 0, 0, 1, 4'b0001, 4'b0000);
        // Hold at terminal count, then wrap.
        cyc("t5_hold0",  0, 0, 0, 1, 0, 4'd0,  4'd9, 0, 0, 0, 1, 4'b0000, 4'b0000);
        cyc("t5_hold1",  0, 0, 0, 1, 0, 4'd0,  4'd9, 0, 0, 0, 1, 4'b0000, 4'b0000);
        cyc("t5_hold2",  0, 0, 0, 1, 0, 4'd0,  4'd9, 0, 0, 0, 1, 4'b0000, 4'b0000);
        cyc("t5_wrap",   0, 0, 1, 1, 0, 4'd0,  4'd9, 1, 0, 0, 1, 4'b0000, 4'b1001);
        cyc("t5_after",  0, 0, 0, 1, 1, 4'd3,  4'd0, 0, 1, 0, 1, 4'b0011, 4'b0000);
        // Asynchronous reset mid-cycle, with and without a pulse in flight.
        cyc("t6_3to4",   0, 0, 1, 1, 0, 4'd0,  4'd3, 0, 0, 0, 1, 4'b0100, 4'b0011);
        cyc("t6_rstmid", 0, 1, 1, 1, 0, 4'd0,  4'd0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        cyc("t6_rsthold",1, 0, 1, 1, 0, 4'd0,  4'd0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        cyc("t6_rel",    0, 0, 1, 1, 0, 4'd0,  4'd0, 0, 0, 0, 1, 4'b0001, 4'b0000);
        cyc("t6_ld15",   0, 0, 0, 1, 1, 4'd15, 4'd1, 0, 0, 0, 1, 4'b1000, 4'b0000);
        cyc("t6_lerst",  0, 1, 0, 1, 0, 4'd0,  4'd0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        cyc("t6_rsth2",  1, 0, 0, 1, 0, 4'd0,  4'd0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        cyc("t6_rel2",   0, 0, 1, 1, 0, 4'd0,  4'd0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        cyc("t6_resume", 0, 0, 0, 1, 0, 4'd0,  4'd1, 0, 0, 0, 1, 4'b0000, 4'b0000);
        @(negedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
        end
        stim_done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
